// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: bimodal 2-bit counters plus a direct-mapped BTB,
// trained by resolved branch/jal outcomes from EX.
module branch_predictor #(
    parameter int XLEN     = 32,
    parameter int IDX_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_target,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    output logic            mispredict,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     branch_cnt,
    output logic [31:0]     mispred_cnt
);

    localparam int ENTRIES = 1 << IDX_BITS;
    localparam int TAG_W   = XLEN - IDX_BITS - 2;

    logic             valid_r  [ENTRIES];
    logic [TAG_W-1:0] tag_r    [ENTRIES];
    logic [XLEN-1:0]  target_r [ENTRIES];
    logic             jal_r    [ENTRIES];
    logic [1:0]       ctr_r    [ENTRIES];

    logic [IDX_BITS-1:0] if_idx_s, ex_idx_s;
    logic [TAG_W-1:0]    if_tag_s, ex_tag_s;
    logic                if_hit_s, ex_hit_s, ex_ctl_s, upd_s;
    logic [1:0]          ctr_next_s;
    logic                unused_s;

    assign if_idx_s = if_pc[IDX_BITS+1:2];
    assign if_tag_s = if_pc[XLEN-1:IDX_BITS+2];
    assign ex_idx_s = ex_pc[IDX_BITS+1:2];
    assign ex_tag_s = ex_pc[XLEN-1:IDX_BITS+2];
    assign ex_ctl_s = ex_is_branch || ex_is_jal;
    assign upd_s    = ex_valid && ex_ctl_s;
    assign ex_hit_s = valid_r[ex_idx_s] && (tag_r[ex_idx_s] == ex_tag_s);
    assign unused_s = &{1'b0, if_pc[1:0]};

    // Lookup reads only registered state, so a same-cycle update is not bypassed
    always_comb begin
        if_hit_s    = valid_r[if_idx_s] && (tag_r[if_idx_s] == if_tag_s);
        pred_taken  = if_hit_s && (jal_r[if_idx_s] || ctr_r[if_idx_s][1]);
        if (pred_taken) begin
            pred_target = target_r[if_idx_s];
        end else begin
            pred_target = {XLEN{1'b0}};
        end
    end

    // Saturating counter step for a branch that hits its entry
    always_comb begin
        ctr_next_s = ctr_r[ex_idx_s];
        case ({ex_taken, ctr_r[ex_idx_s]})
            3'b1_00: ctr_next_s = 2'b01;
            3'b1_01: ctr_next_s = 2'b10;
            3'b1_10: ctr_next_s = 2'b11;
            3'b1_11: ctr_next_s = 2'b11;
            3'b0_00: ctr_next_s = 2'b00;
            3'b0_01: ctr_next_s = 2'b00;
            3'b0_10: ctr_next_s = 2'b01;
            3'b0_11: ctr_next_s = 2'b10;
            default: ctr_next_s = 2'b01;
        endcase
    end

    // Mispredict detection and the corrected next PC; the stale-alias case has no ctl
    always_comb begin
        if (rst || !ex_valid) begin
            mispredict = 1'b0;
        end else if (ex_ctl_s) begin
            mispredict = (ex_taken != ex_pred_taken) ||
                         (ex_taken && ex_pred_taken && (ex_target != ex_pred_target));
        end else begin
            mispredict = ex_pred_taken;
        end
        if (ex_ctl_s && ex_taken) begin
            redirect_pc = ex_target;
        end else begin
            redirect_pc = ex_pc + {{(XLEN-3){1'b0}}, 3'd4};
        end
    end

    // Table training from resolved EX outcomes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {TAG_W{1'b0}};
                target_r[i] <= {XLEN{1'b0}};
                jal_r[i]    <= 1'b0;
                ctr_r[i]    <= 2'b01;
            end
        end else if (upd_s) begin
            if (ex_is_jal) begin
                valid_r[ex_idx_s]  <= 1'b1;
                tag_r[ex_idx_s]    <= ex_tag_s;
                target_r[ex_idx_s] <= ex_target;
                jal_r[ex_idx_s]    <= 1'b1;
                ctr_r[ex_idx_s]    <= 2'b11;
            end else if (ex_hit_s) begin
                ctr_r[ex_idx_s] <= ctr_next_s;
                if (ex_taken) begin
                    target_r[ex_idx_s] <= ex_target;
                end
            end else begin
                valid_r[ex_idx_s]  <= 1'b1;
                tag_r[ex_idx_s]    <= ex_tag_s;
                target_r[ex_idx_s] <= ex_target;
                jal_r[ex_idx_s]    <= 1'b0;
                ctr_r[ex_idx_s]    <= ex_taken ? 2'b10 : 2'b01;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt  <= 32'd0;
            mispred_cnt <= 32'd0;
        end else begin
            if (upd_s && (branch_cnt != 32'hFFFF_FFFF)) begin
                branch_cnt <= branch_cnt + 32'd1;
            end
            if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) begin
                mispred_cnt <= mispred_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed-vector bench for branch_predictor: table of hand-computed lookups and
// resolves, plus reset-during-update and counter checks.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic [31:0] ex_pc = 32'd0;
    logic        ex_is_branch = 1'b0;
    logic        ex_is_jal = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_target = 32'd0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = 32'd0;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] branch_cnt;
    logic [31:0] mispred_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    branch_predictor #(.XLEN(32), .IDX_BITS(4)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_is_branch(ex_is_branch),
        .ex_is_jal(ex_is_jal), .ex_taken(ex_taken), .ex_target(ex_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] if_pc;
        logic        v;
        logic [31:0] pc;
        logic        br;
        logic        jal;
        logic        tk;
        logic [31:0] tgt;
        logic        ptk;
        logic [31:0] ptgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_mp;
        logic [31:0] e_rd;
    } vec_t;

    vec_t vecs [19];

    function automatic vec_t mk(input logic [31:0] ipc, input logic v, input logic [31:0] pc,
                                input logic br, input logic jal, input logic tk,
                                input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt,
                                input logic e_pt, input logic [31:0] e_ptgt,
                                input logic e_mp, input logic [31:0] e_rd);
        vec_t r;
        r.if_pc = ipc; r.v = v; r.pc = pc; r.br = br; r.jal = jal; r.tk = tk;
        r.tgt = tgt; r.ptk = ptk; r.ptgt = ptgt;
        r.e_pt = e_pt; r.e_ptgt = e_ptgt; r.e_mp = e_mp; r.e_rd = e_rd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        ex_valid = 1'b0; ex_pc = 32'd0; ex_is_branch = 1'b0; ex_is_jal = 1'b0;
        ex_taken = 1'b0; ex_target = 32'd0; ex_pred_taken = 1'b0; ex_pred_target = 32'd0;
    endtask

    initial begin
        //            if_pc         v     ex_pc         br    jal   tk    tgt           ptk   ptgt          e_pt  e_ptgt        e_mp  e_rd
        vecs[0]  = mk(32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h4);
        vecs[1]  = mk(32'h100, 1'b1, 32'h100,      1'b1, 1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80);
        vecs[2]  = mk(32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h4);
        vecs[3]  = mk(32'h100, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104);
        vecs[4]  = mk(32'h100, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h104);
        vecs[5]  = mk(32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h4);
        vecs[6]  = mk(32'h200, 1'b1, 32'h200,      1'b0, 1'b1, 1'b1, 32'h400, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400);
        vecs[7]  = mk(32'h200, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h400, 1'b0, 32'h4);
        vecs[8]  = mk(32'h200, 1'b1, 32'h200,      1'b0, 1'b1, 1'b1, 32'h400, 1'b1, 32'h3FC, 1'b1, 32'h400, 1'b1, 32'h400);
        vecs[9]  = mk(32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h4);
        vecs[10] = mk(32'h300, 1'b1, 32'h100,      1'b1, 1'b0, 1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80);
        vecs[11] = mk(32'h100, 1'b1, 32'h1100,     1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h1104);
        vecs[12] = mk(32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h4);
        vecs[13] = mk(32'h1100, 1'b0, 32'h0,       1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h4);
        vecs[14] = mk(32'h100, 1'b1, 32'h100,      1'b1, 1'b0, 1'b0, 32'h80,  1'b1, 32'h80,  1'b1, 32'h80,  1'b1, 32'h104);
        vecs[15] = mk(32'h100, 1'b0, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h0,   1'b0, 32'h4);
        vecs[16] = mk(32'h100, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h10,  1'b0, 32'h0,   1'b1, 32'h0);
        vecs[17] = mk(32'h100, 1'b0, 32'h500,      1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h504);
        vecs[18] = mk(32'h100, 1'b1, 32'h100,      1'b1, 1'b0, 1'b1, 32'h80,  1'b1, 32'h80,  1'b0, 32'h0,   1'b0, 32'h80);

        // Reset, then four idle cycles
        drive_idle();
        if_pc = 32'h100;
        repeat (2) @(negedge clk);
        #1;
        check("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("rst_mispredict", {31'd0, mispredict}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #1;
        check("idle_pred_taken", {31'd0, pred_taken}, 32'd0);
        check("idle_branch_cnt", branch_cnt, 32'd0);
        check("idle_mispred_cnt", mispred_cnt, 32'd0);

        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if_pc = vecs[i].if_pc;
            ex_valid = vecs[i].v; ex_pc = vecs[i].pc; ex_is_branch = vecs[i].br;
            ex_is_jal = vecs[i].jal; ex_taken = vecs[i].tk; ex_target = vecs[i].tgt;
            ex_pred_taken = vecs[i].ptk; ex_pred_target = vecs[i].ptgt;
            #1;
            check($sformatf("v%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
            check($sformatf("v%0d_pred_target", i), pred_target, vecs[i].e_ptgt);
            check($sformatf("v%0d_mispredict", i), {31'd0, mispredict}, {31'd0, vecs[i].e_mp});
            check($sformatf("v%0d_redirect_pc", i), redirect_pc, vecs[i].e_rd);
        end

        @(negedge clk);
        drive_idle();
        #1;
        check("seq_branch_cnt", branch_cnt, 32'd9);
        check("seq_mispred_cnt", mispred_cnt, 32'd8);

        // rst asserted during a qualifying update discards it
        @(negedge clk);
        if_pc = 32'h144;
        ex_valid = 1'b1; ex_pc = 32'h144; ex_is_branch = 1'b1; ex_taken = 1'b1;
        ex_target = 32'h20; ex_pred_taken = 1'b0;
        rst = 1'b1;
        #1;
        check("rstupd_mispredict", {31'd0, mispredict}, 32'd0);
        check("rstupd_branch_cnt", branch_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive_idle();
        #1;
        check("post_rst_pred_144", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'h100;
        #1;
        check("post_rst_pred_100", {31'd0, pred_taken}, 32'd0);
        @(negedge clk);
        #1;
        check("post_rst_branch_cnt", branch_cnt, 32'd0);
        check("post_rst_mispred_cnt", mispred_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
